// File: rtl/uart_fsm_rx.sv
// 8N1 UART receiver: 2-flop synchronised RxD, mid-bit sampling, byte strobe and bad-stop strobe.
// Latency 2+HALF+9*DIVIDER+1 clocks from rx_i fall to valid_o; no backpressure, pulses last one cycle.
module uart_fsm_rx #(
    parameter logic [31:0] FREQUENCY = 32'd50_000_000,
    parameter logic [31:0] SPEED     = 32'd1_500_000
) (
    input  logic       clk_i,
    input  logic       reset_n,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       busy_o
);
    localparam logic [31:0] DIVIDER = FREQUENCY / SPEED;
    localparam logic [31:0] HALF    = DIVIDER / 2;
    localparam int          TW      = $clog2(DIVIDER);

    localparam logic [TW-1:0] TICK_LAST = TW'(DIVIDER - 32'd1);
    localparam logic [TW-1:0] TICK_HALF = TW'(HALF - 32'd1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic          r_rx_meta;
    logic          r_rx_s;
    logic [1:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic [7:0]    r_data;
    logic          r_valid;
    logic          r_ferr;
    logic          r_busy;

    always_ff @(posedge clk_i) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_rx_meta <= rx_i;
            r_rx_s    <= r_rx_meta;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
            // Lags the state by one cycle so busy_o covers the strobe cycle.
            r_busy    <= (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) begin
                        r_state <= S_START;
                        r_tick  <= '0;
                    end
                end
                S_START: begin
                    if (r_tick == TICK_HALF) begin
                        r_tick  <= '0;
                        r_bit   <= '0;
                        r_state <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_DATA: begin
                    if (r_tick == TICK_LAST) begin
                        r_tick         <= '0;
                        r_shift[r_bit] <= r_rx_s;
                        r_bit          <= r_bit + 3'd1;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                S_STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
                    if (r_tick == TICK_LAST) begin
                        r_tick  <= '0;
                        r_state <= S_IDLE;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                        end else begin
                            r_ferr <= 1'b1;
                        end
                    end else begin
                        r_tick <= r_tick + TW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign data_o      = r_data;
    assign valid_o     = r_valid;
    assign frame_err_o = r_ferr;
    assign busy_o      = r_busy;
endmodule

// File: tb/tb_uart_fsm_rx.sv
// Bench for uart_fsm_rx: frames driven on the line, strobes compared against a frame-level model.
module tb_uart_fsm_rx;
    localparam int BIT = 33;
    localparam int DIV = 50_000_000 / 1_500_000;
    localparam int HLF = DIV / 2;
    localparam int LAT = 2 + HLF + 9 * DIV + 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       rx;
    logic       rx2;
    logic [7:0] data_o, data2_o;
    logic       valid_o, frame_err_o, busy_o;
    logic       valid2_o, ferr2_o, busy2_o;

    always #5 clk = ~clk;

    uart_fsm_rx dut (
        .clk_i(clk), .reset_n(reset_n), .rx_i(rx),
        .data_o(data_o), .valid_o(valid_o), .frame_err_o(frame_err_o), .busy_o(busy_o)
    );

    uart_fsm_rx #(.FREQUENCY(32'd50_000_000), .SPEED(32'd1_455_000)) dut_slow (
        .clk_i(clk), .reset_n(reset_n), .rx_i(rx2),
        .data_o(data2_o), .valid_o(valid2_o), .frame_err_o(ferr2_o), .busy_o(busy2_o)
    );

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Observed strobes (kind 1 = byte, 2 = stop error) and expected ones from the frame model.
    int         ev_kind[$];
    logic [7:0] ev_data[$];
    int         ev_cyc[$];
    int         exp_kind[$];
    logic [7:0] exp_data[$];
    int         exp_cyc[$];
    logic [7:0] last_good = 8'h00;
    logic [7:0] ev2_data[$];
    int         ev2_err   = 0;
    int         overlap   = 0;
    int         busy_seen = 0;

    always @(negedge clk) begin
        if (valid_o) begin
            ev_kind.push_back(1); ev_data.push_back(data_o); ev_cyc.push_back(cyc);
        end
        if (frame_err_o) begin
            ev_kind.push_back(2); ev_data.push_back(data_o); ev_cyc.push_back(cyc);
        end
        if (valid_o && frame_err_o) overlap++;
        if (busy_o) busy_seen++;
        if (valid2_o) ev2_data.push_back(data2_o);
        if (ferr2_o) ev2_err++;
    end

    // Called at a negedge; the line falls now, so the strobe is due LAT cycles later.
    task automatic send_frame(input logic [7:0] b, input logic stop);
        logic [9:0] f;
        f = {stop, b, 1'b0};
        exp_kind.push_back(stop ? 1 : 2);
        exp_data.push_back(stop ? b : last_good);
        exp_cyc.push_back(cyc + LAT);
        if (stop) last_good = b;
        for (int k = 0; k < 10; k++) begin
            rx = f[k];
            repeat (BIT) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; rx = 1'b1; rx2 = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", data_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_o); end
        checks++; if (frame_err_o !== 1'b0) begin errors++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy_o); end
        checks++; if (busy2_o !== 1'b0 || data2_o !== 8'h00) begin
            errors++; $display("FAIL reset_slow: got busy=%b data=%h want 0/00", busy2_o, data2_o);
        end
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic test_single;
        int k, ek, c, ec; logic [7:0] d, ed;
        send_frame(8'hA5, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++; $display("FAIL single_count: got %0d strobes want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); c = ev_cyc.pop_front();
            ek = exp_kind.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
            checks++;
            if (k != ek || d !== ed || c < ec - 1 || c > ec + 1) begin
                errors++;
                $display("FAIL single_event: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", k, d, c, ek, ed, ec);
            end
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data.delete(); exp_cyc.delete();
        checks++; if (data_o !== 8'hA5) begin errors++; $display("FAIL single_hold: got %h want a5", data_o); end
    endtask

    task automatic test_back_to_back;
        int k, ek, c, ec; logic [7:0] d, ed;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_frame(8'h3C, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++; $display("FAIL b2b_count: got %0d strobes want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); c = ev_cyc.pop_front();
            ek = exp_kind.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
            checks++;
            if (k != ek || d !== ed || c < ec - 1 || c > ec + 1) begin
                errors++;
                $display("FAIL b2b_event: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", k, d, c, ek, ed, ec);
            end
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data.delete(); exp_cyc.delete();
    endtask

    task automatic test_frame_err;
        int k, ek, c, ec; logic [7:0] d, ed;
        send_frame(8'h81, 1'b0);
        repeat (40) @(negedge clk);
        checks++; if (data_o !== last_good) begin errors++; $display("FAIL ferr_hold: got %h want %h", data_o, last_good); end
        send_frame(8'h42, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++; $display("FAIL ferr_count: got %0d strobes want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); c = ev_cyc.pop_front();
            ek = exp_kind.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
            checks++;
            if (k != ek || d !== ed || c < ec - 1 || c > ec + 1) begin
                errors++;
                $display("FAIL ferr_event: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", k, d, c, ek, ed, ec);
            end
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data.delete(); exp_cyc.delete();
    endtask

    task automatic test_glitch;
        busy_seen = 0;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (HLF + 10) @(negedge clk);
        checks++; if (busy_seen == 0) begin errors++; $display("FAIL glitch_busy_seen: got 0 busy cycles want >0"); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL glitch_idle: got busy=%b want 0", busy_o); end
        checks++; if (ev_kind.size() != 0) begin errors++; $display("FAIL glitch_strobe: got %0d strobes want 0", ev_kind.size()); end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
    endtask

    task automatic test_reset_mid;
        int k, ek, c, ec; logic [7:0] d, ed, b;
        logic [9:0] f;
        b = 8'($urandom);
        f = {1'b1, b, 1'b0};
        for (int i = 0; i < 5; i++) begin
            rx = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx = f[5];
        repeat (BIT / 2) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        rx = 1'b1;
        last_good = 8'h00;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", busy_o); end
        checks++; if (valid_o !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b want 0", valid_o); end
        checks++; if (data_o !== 8'h00) begin errors++; $display("FAIL midreset_data: got %h want 00", data_o); end
        repeat (BIT * 6) @(negedge clk);
        checks++; if (ev_kind.size() != 0) begin errors++; $display("FAIL midreset_strobe: got %0d strobes want 0", ev_kind.size()); end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        send_frame(8'h5A, 1'b1);
        repeat (20) @(negedge clk);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++; $display("FAIL midreset_count: got %0d strobes want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); c = ev_cyc.pop_front();
            ek = exp_kind.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
            checks++;
            if (k != ek || d !== ed || c < ec - 1 || c > ec + 1) begin
                errors++;
                $display("FAIL midreset_event: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", k, d, c, ek, ed, ec);
            end
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data.delete(); exp_cyc.delete();
    endtask

    task automatic test_random;
        int k, ek, c, ec, gap; logic [7:0] d, ed, b; logic stop;
        for (int n = 0; n < 8; n++) begin
            b    = 8'($urandom);
            stop = ($urandom_range(0, 3) != 0);
            send_frame(b, stop);
            // A low stop bit needs a real idle gap, or the next start edge cannot be seen.
            gap = stop ? $urandom_range(0, 10) : $urandom_range(20, 30);
            repeat (gap) @(negedge clk);
        end
        repeat (40) @(negedge clk);
        checks++;
        if (ev_kind.size() != exp_kind.size()) begin
            errors++; $display("FAIL random_count: got %0d strobes want %0d", ev_kind.size(), exp_kind.size());
        end
        while (ev_kind.size() > 0 && exp_kind.size() > 0) begin
            k = ev_kind.pop_front(); d = ev_data.pop_front(); c = ev_cyc.pop_front();
            ek = exp_kind.pop_front(); ed = exp_data.pop_front(); ec = exp_cyc.pop_front();
            checks++;
            if (k != ek || d !== ed || c < ec - 1 || c > ec + 1) begin
                errors++;
                $display("FAIL random_event: got kind=%0d data=%h cyc=%0d want kind=%0d data=%h cyc=%0d", k, d, c, ek, ed, ec);
            end
        end
        ev_kind.delete(); ev_data.delete(); ev_cyc.delete();
        exp_kind.delete(); exp_data.delete(); exp_cyc.delete();
    endtask

    task automatic test_slow_receiver;
        logic [9:0] f;
        f = {1'b1, 8'hC3, 1'b0};
        for (int i = 0; i < 10; i++) begin
            rx2 = f[i];
            repeat (BIT) @(negedge clk);
        end
        rx2 = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (ev2_data.size() != 1) begin errors++; $display("FAIL slow_count: got %0d strobes want 1", ev2_data.size()); end
        checks++;
        if (ev2_data.size() == 0 || ev2_data[0] !== 8'hC3) begin
            errors++; $display("FAIL slow_data: got %h want c3", (ev2_data.size() > 0) ? ev2_data[0] : 8'hxx);
        end
        checks++; if (ev2_err != 0) begin errors++; $display("FAIL slow_ferr: got %0d errors want 0", ev2_err); end
    endtask

    initial begin
        @(negedge clk);
        test_reset;
        test_single;
        test_back_to_back;
        test_frame_err;
        test_glitch;
        test_reset_mid;
        test_random;
        test_slow_receiver;
        checks++; if (overlap != 0) begin errors++; $display("FAIL strobe_overlap: got %0d cycles want 0", overlap); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
